// File: rtl/riscv_rf_arb_pkg.sv
// Shared constants and payload type for the register-file writeback arbiter.
package riscv_rf_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT = 4;

    localparam int unsigned WB_ALU  = 0;
    localparam int unsigned WB_LSU  = 1;
    localparam int unsigned WB_MULT = 2;
    localparam int unsigned WB_FPU  = 3;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;

    // One regfile write as it appears on a write port.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
        logic                 we;
    } rf_wr_t;

endpackage

// File: rtl/riscv_rf_arb_pick.sv
// Find-first valid requester scanning circularly from a start index,
// skipping requesters whose destination matches an excluded address.
module riscv_rf_arb_pick
    import riscv_rf_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = NUM_REQ_DEFAULT,
    parameter  int unsigned ADDR_WIDTH = 5,
    localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                 i_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] i_addr,
    input  logic [IDX_W-1:0]                   i_start,
    input  logic                               i_excl_en,
    input  logic [ADDR_WIDTH-1:0]              i_excl_addr,
    output logic                               o_found_c,
    output logic [IDX_W-1:0]                   o_idx_c
);

    int unsigned w_pos;

    always_comb begin
        o_found_c = 1'b0;
        o_idx_c   = '0;
        w_pos     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = (32'(i_start) + k) % NUM_REQ;
            if (!o_found_c && i_valid[IDX_W'(w_pos)] &&
                !(i_excl_en && (i_addr[IDX_W'(w_pos)] == i_excl_addr))) begin
                o_found_c = 1'b1;
                o_idx_c   = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// Two-port regfile writeback arbiter with registered write ports and pending bitmap.
// Define RF_WB_ARB_ROUND_ROBIN_EN for round-robin scan; otherwise fixed priority (req 0 highest).
module riscv_rf_wb_arbiter
    import riscv_rf_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [ADDR_WIDTH-1:0]              waddr_a_o,
    output logic [DATA_WIDTH-1:0]              wdata_a_o,
    output logic                               we_a_o,
    output logic [ADDR_WIDTH-1:0]              waddr_b_o,
    output logic [DATA_WIDTH-1:0]              wdata_b_o,
    output logic                               we_b_o,
    output logic [(2**ADDR_WIDTH)-1:0]         wr_pend_o
);

    localparam int unsigned IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

    logic [IDX_W-1:0]      w_start;
    logic                  w_found_a;
    logic                  w_found_b;
    logic [IDX_W-1:0]      w_idx_a;
    logic [IDX_W-1:0]      w_idx_b;
    logic [NUM_REQ-1:0]    w_valid_b;
    logic [ADDR_WIDTH-1:0] w_addr_a;
    logic [ADDR_WIDTH-1:0] w_addr_b;
    logic [NUM_REGS-1:0]   w_pend_nxt;

    logic [ADDR_WIDTH-1:0] r_waddr_a;
    logic [DATA_WIDTH-1:0] r_wdata_a;
    logic                  r_we_a;
    logic [ADDR_WIDTH-1:0] r_waddr_b;
    logic [DATA_WIDTH-1:0] r_wdata_b;
    logic                  r_we_b;
    logic [NUM_REGS-1:0]   r_wr_pend;

`ifdef RF_WB_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_last;

    // Port B is always later in scan order than port A, so it is the last grant when present.
    assign w_last = w_found_b ? w_idx_b : w_idx_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found_a) begin
            r_ptr <= (32'(w_last) == NUM_REQ - 1) ? '0 : w_last + IDX_W'(1);
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    riscv_rf_arb_pick #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pick_a (
        .i_valid     (req_valid_i),
        .i_addr      (req_addr_i),
        .i_start     (w_start),
        .i_excl_en   (1'b0),
        .i_excl_addr ('0),
        .o_found_c   (w_found_a),
        .o_idx_c     (w_idx_a)
    );

    assign w_addr_a  = req_addr_i[w_idx_a];
    assign w_valid_b = req_valid_i & ~(NUM_REQ'(1) << w_idx_a);

    riscv_rf_arb_pick #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pick_b (
        .i_valid     (w_valid_b),
        .i_addr      (req_addr_i),
        .i_start     (w_start),
        .i_excl_en   (w_found_a),
        .i_excl_addr (w_addr_a),
        .o_found_c   (w_found_b),
        .o_idx_c     (w_idx_b)
    );

    assign w_addr_b = req_addr_i[w_idx_b];

    // Nothing is acknowledged while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (rst_n) begin
            if (w_found_a) req_ready_o[w_idx_a] = 1'b1;
            if (w_found_b) req_ready_o[w_idx_b] = 1'b1;
        end
    end

    always_comb begin
        w_pend_nxt = '0;
        if (w_found_a && (w_addr_a != '0)) w_pend_nxt[w_addr_a] = 1'b1;
        if (w_found_b && (w_addr_b != '0)) w_pend_nxt[w_addr_b] = 1'b1;
    end

    // x0 writes are accepted and captured but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr_a <= '0;
            r_wdata_a <= '0;
            r_we_a    <= 1'b0;
            r_waddr_b <= '0;
            r_wdata_b <= '0;
            r_we_b    <= 1'b0;
            r_wr_pend <= '0;
        end else begin
            r_we_a    <= w_found_a && (w_addr_a != '0);
            r_we_b    <= w_found_b && (w_addr_b != '0);
            r_wr_pend <= w_pend_nxt;
            if (w_found_a) begin
                r_waddr_a <= w_addr_a;
                r_wdata_a <= req_data_i[w_idx_a];
            end
            if (w_found_b) begin
                r_waddr_b <= w_addr_b;
                r_wdata_b <= req_data_i[w_idx_b];
            end
        end
    end

    assign waddr_a_o = r_waddr_a;
    assign wdata_a_o = r_wdata_a;
    assign we_a_o    = r_we_a;
    assign waddr_b_o = r_waddr_b;
    assign wdata_b_o = r_wdata_b;
    assign we_b_o    = r_we_b;
    assign wr_pend_o = r_wr_pend;

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Self-checking bench for riscv_rf_wb_arbiter: directed scenarios plus random traffic
// against a queue-based scan-order model and a shadow register file.
module tb_riscv_rf_wb_arbiter;
    import riscv_rf_arb_pkg::*;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int N    = 4;
    localparam int IW   = $clog2(N);
    localparam int NREG = 2**AW;
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_data;
    logic [N-1:0]         req_ready;
    logic [AW-1:0]        waddr_a, waddr_b;
    logic [DW-1:0]        wdata_a, wdata_b;
    logic                 we_a, we_b;
    logic [NREG-1:0]      wr_pend;

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;

    rf_wr_t   e_a, e_b;     // expected port contents this cycle
    rf_wr_t   s_a, s_b;     // observed port contents this cycle
    logic [DW-1:0] exp_rf [NREG];
    logic [DW-1:0] obs_rf [NREG];

    riscv_rf_wb_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .waddr_a_o   (waddr_a),
        .wdata_a_o   (wdata_a),
        .we_a_o      (we_a),
        .waddr_b_o   (waddr_b),
        .wdata_b_o   (wdata_b),
        .we_b_o      (we_b),
        .wr_pend_o   (wr_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scan order list of valid requesters; A is its head, B the next one with a different address.
    function automatic void pick(output int ga, output int gb);
        int q[$];
        ga = -1;
        gb = -1;
        for (int k = 0; k < N; k++) begin
            int j = (mptr + k) % N;
            if (req_valid[IW'(j)]) q.push_back(j);
        end
        if (q.size() == 0) return;
        ga = q[0];
        for (int i = 1; i < q.size(); i++)
            if (gb < 0 && req_addr[IW'(q[i])] != req_addr[IW'(ga)]) gb = q[i];
    endfunction

    task automatic check_outputs(input string tag);
        logic [NREG-1:0] pend;
        pend = '0;
        if (e_a.we) pend[e_a.addr] = 1'b1;
        if (e_b.we) pend[e_b.addr] = 1'b1;
        chk({tag, "/we_a"},    64'(we_a),    64'(e_a.we));
        chk({tag, "/waddr_a"}, 64'(waddr_a), 64'(e_a.addr));
        chk({tag, "/wdata_a"}, 64'(wdata_a), 64'(e_a.data));
        chk({tag, "/we_b"},    64'(we_b),    64'(e_b.we));
        chk({tag, "/waddr_b"}, 64'(waddr_b), 64'(e_b.addr));
        chk({tag, "/wdata_b"}, 64'(wdata_b), 64'(e_b.data));
        chk({tag, "/wr_pend"}, 64'(wr_pend), 64'(pend));
        s_a = '{addr: waddr_a, data: wdata_a, we: we_a};
        s_b = '{addr: waddr_b, data: wdata_b, we: we_b};
    endtask

    // One clock: check ready, advance the model, retire accepted requests, check outputs.
    task automatic step(input string tag);
        int ga, gb;
        logic [N-1:0] er;
        #1;
        pick(ga, gb);
        er = '0;
        if (ga >= 0) er[IW'(ga)] = 1'b1;
        if (gb >= 0) er[IW'(gb)] = 1'b1;
        chk({tag, "/ready"}, 64'(req_ready), 64'(er));
        @(posedge clk);
        if (e_a.we) exp_rf[e_a.addr] = e_a.data;
        if (e_b.we) exp_rf[e_b.addr] = e_b.data;
        if (s_a.we) obs_rf[s_a.addr] = s_a.data;
        if (s_b.we) obs_rf[s_b.addr] = s_b.data;
        e_a.we = 1'b0;
        e_b.we = 1'b0;
        if (ga >= 0) begin
            e_a.addr = req_addr[IW'(ga)];
            e_a.data = req_data[IW'(ga)];
            e_a.we   = (req_addr[IW'(ga)] != '0);
        end
        if (gb >= 0) begin
            e_b.addr = req_addr[IW'(gb)];
            e_b.data = req_data[IW'(gb)];
            e_b.we   = (req_addr[IW'(gb)] != '0);
        end
        if (RR && ga >= 0) mptr = (((gb >= 0) ? gb : ga) + 1) % N;
        #1;
        if (ga >= 0) req_valid[IW'(ga)] = 1'b0;
        if (gb >= 0) req_valid[IW'(gb)] = 1'b0;
        check_outputs(tag);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[IW'(i)] = 1'b1;
        req_addr[IW'(i)]  = a;
        req_data[IW'(i)]  = d;
    endtask

    // Asynchronous reset: outputs clear at once, in-flight writes are dropped.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        e_a  = '0;
        e_b  = '0;
        mptr = 0;
        chk("reset/ready", 64'(req_ready), 64'd0);
        check_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rr_tab [4];
        logic [DW-1:0] exp5;

        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        s_a = '0;
        s_b = '0;
        for (int r = 0; r < NREG; r++) begin
            exp_rf[r] = '0;
            obs_rf[r] = '0;
        end
        do_reset();

        // Distinct addresses on requesters 0 and 2.
        set_req(0, 5'd3, 32'h11);
        set_req(2, 5'd7, 32'h22);
        #1;
        chk("dist/ready_const", 64'(req_ready), 64'b0101);
        step("dist");
        chk("dist/a_const", {32'(waddr_a), wdata_a}, {32'd3, 32'h11});
        chk("dist/b_const", {32'(waddr_b), wdata_b}, {32'd7, 32'h22});
        chk("dist/pend_const", 64'(wr_pend), 64'h88);
        step("idle");

        // Same destination from two requesters: serialised on port A.
        set_req(1, 5'd5, 32'hA1);
        set_req(3, 5'd5, 32'hB3);
        step("coll0");
        chk("coll0/we_b_const", 64'(we_b), 64'd0);
        step("coll1");
        chk("coll1/we_b_const", 64'(we_b), 64'd0);
        step("coll_flush");
        step("coll_flush2");
        exp5 = RR ? 32'hA1 : 32'hB3;
        chk("coll/rf5", 64'(obs_rf[5]), 64'(exp5));

        // x0 write is acknowledged but not enabled.
        set_req(0, 5'd0, 32'hDEAD);
        #1;
        chk("x0/ready0", 64'(req_ready[0]), 64'd1);
        step("x0");
        chk("x0/we_a_const", 64'(we_a), 64'd0);
        chk("x0/pend_const", 64'(wr_pend), 64'd0);

        // Single requester streaming to one register.
        for (int n = 0; n < 3; n++) begin
            set_req(2, 5'd9, 32'h900 + 32'(n));
            step("stream");
            chk("stream/a_const", {31'(0), we_a, wdata_a}, {31'(0), 1'b1, 32'h900 + 32'(n)});
            chk("stream/we_b_const", 64'(we_b), 64'd0);
        end

        // Mid-stream reset with all requesters valid, then scan-order pattern.
        for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), 32'h100 + 32'(i));
        step("pre_rst");
        for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), 32'h200 + 32'(i));
        do_reset();
        rr_tab[0] = 4'b0011;
        rr_tab[1] = RR ? 4'b1100 : 4'b0011;
        rr_tab[2] = 4'b0011;
        rr_tab[3] = RR ? 4'b1100 : 4'b0011;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[IW'(i)]) set_req(i, 5'(10 + i), 32'h300 + 32'(c * N + i));
            #1;
            chk("rr/ready_const", 64'(req_ready), 64'(rr_tab[c]));
            step("rr");
        end
        req_valid = '0;
        step("rr_flush");

        // Random traffic with frequent address collisions and x0 targets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[IW'(i)] && $urandom_range(0, 99) < 60)
                    set_req(i, 5'($urandom_range(0, 7)), $urandom);
            step("rand");
        end
        req_valid = '0;
        step("flush0");
        step("flush1");
        for (int r = 0; r < NREG; r++) chk("final/rf", 64'(obs_rf[r]), 64'(exp_rf[r]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/riscv_rf_wb_arbiter.md
# riscv_rf_wb_arbiter

Writeback arbiter for the core's two-write-port register file. It shares write ports A and B between up to `NUM_REQ` writeback sources (ALU, LSU, mult/div, FPU) using a valid/ready handshake. It never grants two writes to the same register in one cycle. Accepted writes are registered and driven onto the regfile write ports one cycle later. It also exports a pending-write bitmap to the hazard logic.

## Interface
- `ADDR_WIDTH`, 5 — register address width; 6 when the FP regfile is present.
- `DATA_WIDTH`, 32 — write data width.
- `NUM_REQ`, 4 — number of writeback requesters, range 2..8.
- `clk` in 1 — core clock.
- `rst_n` in 1 — reset; asynchronous, active-low. One clock domain only.
- `req_valid_i` in `NUM_REQ` — requester i has a write pending.
- `req_addr_i` in `NUM_REQ` x `ADDR_WIDTH` — destination register per requester.
- `req_data_i` in `NUM_REQ` x `DATA_WIDTH` — write data per requester.
- `req_ready_o` out `NUM_REQ` — requester i accepted this cycle; combinational from the valid and address inputs.
- `waddr_a_o`, `wdata_a_o`, `we_a_o` out `ADDR_WIDTH` / `DATA_WIDTH` / 1 — regfile write port A, registered.
- `waddr_b_o`, `wdata_b_o`, `we_b_o` out `ADDR_WIDTH` / `DATA_WIDTH` / 1 — regfile write port B, registered.
- `wr_pend_o` out 2**`ADDR_WIDTH` — one-hot OR of registers written this cycle (port A | port B).

## Operation
- Handshake: the requester holds valid, addr and data stable until it sees ready high at a rising edge. Transfer happens on the edge where valid & ready are both high. Ready is never high without valid.
- At most two grants per cycle.
- First grant:
  - The first valid requester in scan order goes to port A.
  - The second valid requester in scan order whose addr differs from the port-A addr goes to port B.
  - A requester whose addr equals the port-A addr is not granted and waits.
- Only one valid requester: it goes to port A; `we_b_o` stays 0 next cycle.
- Scan order is set by the configuration (see below).
- x0 writes: an accepted write to address 0 is acknowledged (ready=1). The corresponding `we_*_o` is forced to 0, and address and data are still registered.
  - Address 32 (f0, when `ADDR_WIDTH`=6) is a real register and is written normally.
- Output stage: the granted addr/data/we are registered on every edge. With no grant, `we_*_o`=0 and addr/data hold their last values.
- `wr_pend_o[k]`=1 iff (`we_a_o` & `waddr_a_o`==k) | (`we_b_o` & `waddr_b_o`==k).
- Ordering: two writes from the same requester to the same register in consecutive cycles reach the regfile in acceptance order.

## Timing
- Reset value of all outputs: `we_a_o`=`we_b_o`=0, `waddr_*_o`=0, `wdata_*_o`=0, `wr_pend_o`=0, `req_ready_o`=0. The round-robin pointer resets to 0.
- Latency: a write accepted at edge N drives `we_*_o` during cycle N+1 and updates the regfile at edge N+1.
- Throughput: 2 writes/cycle with distinct addresses; 1/cycle when all pending requesters target the same register.
- Reset mid-operation: the in-flight output-stage write is dropped. No requester is considered accepted unless the handshake edge completed before reset asserted.

## Configuration
- `RF_WB_ARB_ROUND_ROBIN_EN` defined:
  - Scan starts at the round-robin pointer.
  - After any cycle with at least one grant, pointer = (index of the last-granted requester + 1) mod `NUM_REQ`.
  - With no grant, the pointer holds.
  - Guarantees no starvation: a requester waits at most `NUM_REQ`-1 grant cycles.
- `RF_WB_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, requester 0 highest.
  - Pointer register is absent.
  - Starvation of high indices is permitted.

## Structure
- Package `riscv_rf_arb_pkg`:
  - `NUM_REQ` default.
  - Requester index constants `WB_ALU`=0, `WB_LSU`=1, `WB_MULT`=2, `WB_FPU`=3.
  - Typedef `rf_wr_t` {addr, data, we}.
- Sub-module `riscv_rf_arb_pick`: combinational find-first-set from a start index over a valid mask, with an address-exclusion mask. Instantiated twice: port A, and port B with A's pick masked out.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `req_valid_i`=4'b1111 -> all outputs 0 immediately; after release, the first grant goes to requester 0.
- Distinct addresses: req0 addr 3 data 0x11, req2 addr 7 data 0x22, same cycle -> ready=4'b0101. Next cycle: A={3,0x11,1}, B={7,0x22,1}, `wr_pend_o` bits 3 and 7 set.
- Address collision: req1 and req3 both addr 5 -> only one grant per cycle, over two cycles; port B idle both cycles; final regfile value is from the second-granted requester.
- x0 write: req0 addr 0 data 0xDEAD -> ready=1, next cycle `we_a_o`=0, `wr_pend_o`=0.
- Round-robin (macro on): all four requesters valid with distinct addresses for 4 cycles -> grants (0,1), (2,3), (0,1), (2,3). Macro off: grants are always (0,1) and requesters 2/3 never get ready.
- Single requester: req2 streams 3 back-to-back writes to addr 9 -> accepted each cycle, emitted on port A in order, `we_b_o`=0 throughout.
